// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - core, external loader and data-memory signals of the dmem port arbiter
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;

   logic              ext_req;
   logic              ext_we;
   logic              ext_lock;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_gnt;
   logic [DATA_W-1:0] ext_rdata;
   logic              ext_rvalid;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Requesters and the memory model sit on the master side
   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_rdata, core_stall,
      output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      input  ext_gnt, ext_rdata, ext_rvalid,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_rdata, core_stall,
      input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      output ext_gnt, ext_rdata, ext_rvalid,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - single-port data memory arbiter, core priority with ext starvation limit and locked bursts
module dmem_port_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int BURST_MAX    = 4
) (
   input  logic                clk,
   input  logic                rst,
   dmem_port_arbiter_if.slave  bus
);
   typedef enum logic {sCore, sExt} arbState;

   arbState    state;
   arbState    nextState;
   logic [3:0] waitCnt;
   logic [3:0] burstCnt;
   logic       extGrant;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= sCore;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         sCore: if (bus.ext_req && (!bus.core_req || waitCnt == 4'(STARVE_LIMIT - 1)))
                   nextState = sExt;
         sExt:  if (!(bus.ext_req && bus.ext_lock && burstCnt < 4'(BURST_MAX - 1)))
                   nextState = sCore;
         default: nextState = sCore;
      endcase
   end

   always_comb begin
      extGrant       = 1'b0;
      bus.core_stall = 1'b0;
      bus.mem_we     = bus.core_req & bus.core_we;
      bus.mem_addr   = bus.core_addr;
      bus.mem_wdata  = bus.core_wdata;
      if (state == sExt) begin
         extGrant       = bus.ext_req;
         bus.core_stall = bus.core_req;
         bus.mem_we     = bus.ext_req & bus.ext_we;
         bus.mem_addr   = bus.ext_addr;
         bus.mem_wdata  = bus.ext_wdata;
      end
   end

   assign bus.ext_gnt    = extGrant;
   assign bus.core_rdata = bus.mem_rdata;

   // Both counters restart on every ownership change, so the core always wins the first cycle back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         waitCnt  <= '0;
         burstCnt <= '0;
      end else if (state == sCore) begin
         burstCnt <= '0;
         if (nextState == sExt || !bus.ext_req) waitCnt <= '0;
         else if (waitCnt != 4'hf)              waitCnt <= waitCnt + 4'd1;
      end else begin
         waitCnt <= '0;
         if (extGrant) burstCnt <= burstCnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.ext_rdata  <= '0;
         bus.ext_rvalid <= 1'b0;
      end else begin
         bus.ext_rvalid <= extGrant & ~bus.ext_we;
         if (extGrant && !bus.ext_we) bus.ext_rdata <= bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed and randomized bench for dmem_port_arbiter against a cycle reference model
module tb_dmem_port_arbiter;
   localparam int ADDR_W       = 8;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int BURST_MAX    = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dmem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [DATA_W-1:0] ram [256] = '{default: '0};
   always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
   assign bus.mem_rdata = ram[bus.mem_addr];

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model: who owns memory, how long ext has waited, grants in this burst
   bit                extOwns = 1'b0;
   int                waited  = 0;
   int                grants  = 0;
   bit                lastGranted = 1'b0;
   bit                expRvalid = 1'b0;
   logic [DATA_W-1:0] expRdata  = '0;
   logic [DATA_W-1:0] refMem [256] = '{default: '0};

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic setCore(input bit req, input bit we, input logic [7:0] a, input logic [31:0] d);
      bus.core_req = req; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
   endtask

   task automatic setExt(input bit req, input bit we, input bit lock, input logic [7:0] a, input logic [31:0] d);
      bus.ext_req = req; bus.ext_we = we; bus.ext_lock = lock; bus.ext_addr = a; bus.ext_wdata = d;
   endtask

   task automatic resetModel();
      extOwns = 1'b0; waited = 0; grants = 0; lastGranted = 1'b0;
      expRvalid = 1'b0; expRdata = '0;
   endtask

   // Called right after a negedge with inputs driven; ends on the next negedge
   task automatic tick();
      bit                expGnt, expStall, expWe, gRead;
      logic [7:0]        expAddr;
      logic [31:0]       expWdata;
      #1;
      if (!extOwns) begin
         expGnt = 1'b0; expStall = 1'b0;
         expWe = bus.core_req & bus.core_we; expAddr = bus.core_addr; expWdata = bus.core_wdata;
      end else begin
         expGnt = bus.ext_req; expStall = bus.core_req;
         expWe = bus.ext_req & bus.ext_we; expAddr = bus.ext_addr; expWdata = bus.ext_wdata;
      end
      checkVal("ext_gnt",    bus.ext_gnt,    expGnt);
      checkVal("core_stall", bus.core_stall, expStall);
      checkVal("mem_we",     bus.mem_we,     expWe);
      checkVal("mem_addr",   bus.mem_addr,   expAddr);
      checkVal("mem_wdata",  bus.mem_wdata,  expWdata);
      if (!extOwns && bus.core_req && !bus.core_we)
         checkVal("core_rdata", bus.core_rdata, refMem[bus.core_addr]);

      gRead = 1'b0;
      lastGranted = 1'b0;
      if (!extOwns) begin
         if (bus.core_req && bus.core_we) refMem[bus.core_addr] = bus.core_wdata;
         waited = bus.ext_req ? waited + 1 : 0;
         if (bus.ext_req && (!bus.core_req || waited >= STARVE_LIMIT)) begin
            extOwns = 1'b1; waited = 0; grants = 0;
         end
      end else begin
         if (bus.ext_req) begin
            lastGranted = 1'b1;
            grants++;
            if (bus.ext_we) refMem[bus.ext_addr] = bus.ext_wdata;
            else begin gRead = 1'b1; expRdata = refMem[bus.ext_addr]; end
         end
         if (!(bus.ext_req && bus.ext_lock && grants < BURST_MAX)) begin
            extOwns = 1'b0; waited = 0;
         end
      end
      expRvalid = gRead;

      @(negedge clk);
      checkVal("ext_rvalid", bus.ext_rvalid, expRvalid);
      checkVal("ext_rdata",  bus.ext_rdata,  expRdata);
   endtask

   initial begin
      setCore(0, 0, 8'h00, 32'h0);
      setExt(0, 0, 0, 8'h00, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkVal("rst_ext_gnt",    bus.ext_gnt,    1'b0);
      checkVal("rst_core_stall", bus.core_stall, 1'b0);
      checkVal("rst_ext_rvalid", bus.ext_rvalid, 1'b0);
      checkVal("rst_ext_rdata",  bus.ext_rdata,  32'h0);
      @(negedge clk);
      rst = 1'b1;
      resetModel();

      // Core-only store then load
      setCore(1, 1, 8'h10, 32'hDEADBEEF);
      #1 checkVal("core_store_we", bus.mem_we, 1'b1);
      tick();
      setCore(1, 0, 8'h10, 32'h0);
      #1 checkVal("core_load_rdata", bus.core_rdata, 32'hDEADBEEF);
      checkVal("core_load_stall", bus.core_stall, 1'b0);
      tick();

      // Ext write with core idle: grant one cycle after the request
      setCore(0, 0, 8'h00, 32'h0);
      setExt(1, 1, 0, 8'h20, 32'h12345678);
      #1 checkVal("extw_gnt_c0", bus.ext_gnt, 1'b0);
      tick();
      #1 checkVal("extw_gnt_c1", bus.ext_gnt, 1'b1);
      checkVal("extw_mem_we", bus.mem_we, 1'b1);
      tick();
      setExt(0, 0, 0, 8'h00, 32'h0);
      setCore(1, 0, 8'h20, 32'h0);
      #1 checkVal("extw_back_stall", bus.core_stall, 1'b0);
      checkVal("extw_back_rdata", bus.core_rdata, 32'h12345678);
      tick();

      // Starvation: core_req stuck high, ext read granted on cycle 5
      setCore(1, 0, 8'h00, 32'h0);
      setExt(1, 0, 0, 8'h20, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         #1 checkVal("starve_wait_gnt", bus.ext_gnt, 1'b0);
         checkVal("starve_wait_stall", bus.core_stall, 1'b0);
         tick();
      end
      #1 checkVal("starve_gnt", bus.ext_gnt, 1'b1);
      checkVal("starve_stall", bus.core_stall, 1'b1);
      tick();
      setExt(0, 0, 0, 8'h00, 32'h0);
      checkVal("starve_rvalid", bus.ext_rvalid, 1'b1);
      checkVal("starve_rdata", bus.ext_rdata, 32'h12345678);
      #1 checkVal("starve_after_stall", bus.core_stall, 1'b0);
      tick();

      // Locked burst of four reads, forced release after the fourth
      for (int k = 0; k < 4; k++) begin
         setCore(1, 1, 8'(k), $urandom);
         tick();
      end
      setCore(0, 0, 8'h00, 32'h0);
      setExt(1, 0, 1, 8'h00, 32'h0);
      #1 checkVal("burst_gnt_c0", bus.ext_gnt, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         setExt(1, 0, 1, 8'(k), 32'h0);
         #1 checkVal("burst_gnt", bus.ext_gnt, 1'b1);
         tick();
      end
      setExt(1, 0, 1, 8'h04, 32'h0);
      #1 checkVal("burst_release_gnt", bus.ext_gnt, 1'b0);
      tick();
      setExt(0, 0, 0, 8'h00, 32'h0);
      tick();

      // ext_req dropped while owning memory
      setExt(1, 1, 0, 8'h30, 32'hAAAA5555);
      tick();
      setExt(0, 1, 0, 8'h30, 32'hAAAA5555);
      #1 checkVal("drop_gnt", bus.ext_gnt, 1'b0);
      checkVal("drop_mem_we", bus.mem_we, 1'b0);
      tick();
      setCore(1, 1, 8'h31, 32'h00000055);
      #1 checkVal("drop_core_stall", bus.core_stall, 1'b0);
      checkVal("drop_core_we", bus.mem_we, 1'b1);
      tick();

      // Async reset between edges in the middle of a locked burst
      setCore(0, 0, 8'h00, 32'h0);
      setExt(1, 0, 1, 8'h10, 32'h0);
      tick();
      tick();
      setCore(1, 0, 8'h00, 32'h0);
      setExt(1, 0, 1, 8'h11, 32'h0);
      #2 rst = 1'b0;
      #1 checkVal("mid_rst_stall", bus.core_stall, 1'b0);
      checkVal("mid_rst_gnt", bus.ext_gnt, 1'b0);
      checkVal("mid_rst_rvalid", bus.ext_rvalid, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      resetModel();
      setExt(0, 0, 0, 8'h00, 32'h0);
      setCore(1, 1, 8'h40, 32'hCAFEF00D);
      #1 checkVal("post_rst_stall", bus.core_stall, 1'b0);
      checkVal("post_rst_we", bus.mem_we, 1'b1);
      tick();

      // Randomized traffic; an ext request is held until the model says it was granted
      for (int c = 0; c < 1500; c++) begin
         setCore($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 15)), $urandom);
         if (!bus.ext_req || lastGranted)
            setExt($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   8'($urandom_range(0, 15)), $urandom);
         else
            bus.ext_lock = $urandom_range(0, 1) == 1;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
